// File: rtl/mprj_stream_pad_bridge.sv
// Pad-side streaming bridge on the Caravel mprj_io bank: 8-bit ingress FIFO, 16-bit egress skid + output register.
// Optional beat/frame counters are enabled with `define MPRJ_STREAM_PAD_BRIDGE_CNT_EN.
module mprj_stream_pad_bridge #(
   parameter int IN_FIFO_DEPTH = 8,
   parameter int IN_W          = 8,
   parameter int OUT_W         = 16
) (
   input  logic             clock,
   input  logic             rstb,
   input  logic [37:0]      io_in,
   output logic [37:0]      io_out,
   output logic [37:0]      io_oeb,
   output logic [IN_W-1:0]  m_data,
   output logic             m_valid,
   output logic             m_last,
   input  logic             m_ready,
   input  logic [OUT_W-1:0] s_data,
   input  logic             s_valid,
   input  logic             s_last,
   output logic             s_ready,
   output logic             in_ovf
`ifdef MPRJ_STREAM_PAD_BRIDGE_CNT_EN
   ,
   output logic [15:0]      in_beats,
   output logic [15:0]      out_beats,
   output logic [15:0]      in_frames,
   output logic [15:0]      out_frames
`endif
);

   localparam int PTR_W = $clog2(IN_FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Ingress state
   logic             in_ready_q;
   logic             cap_valid_q;
   logic [IN_W:0]    cap_q;
   logic [IN_W:0]    fifo_mem [IN_FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;

   // Egress state
   logic [OUT_W:0]   skid_mem [2];
   logic             skid_wr_q, skid_rd_q;
   logic [1:0]       skid_cnt_q, skid_cnt_next;
   logic             out_valid_q, out_last_q;
   logic [OUT_W-1:0] out_data_q;

   logic [IN_W-1:0]  pad_data;
   logic             pad_beat, fifo_full, fifo_push, fifo_pop, wr_blocked, in_ready_next;
   logic [CNT_W-1:0] count_next_nopop;
   logic             skid_push, skid_pop, out_load;

   // NOTE: every always_comb output gets a default first so no latch can be inferred.
   always_comb begin
      pad_data = '0;
      for (int i = 0; i < IN_W; i++) pad_data[i] = io_in[37-i];
   end

   assign pad_beat   = io_in[28] & in_ready_q;
   assign fifo_full  = (count_q == CNT_W'(IN_FIFO_DEPTH));
   assign m_valid    = (count_q != '0);
   assign fifo_pop   = m_valid & m_ready;
   assign fifo_push  = cap_valid_q & ~fifo_full;
   assign wr_blocked = cap_valid_q & fifo_full;
   assign m_data     = fifo_mem[rd_ptr_q][IN_W-1:0];
   assign m_last     = fifo_mem[rd_ptr_q][IN_W];

   // Pops are deliberately left out: the credit only needs to be safe, not tight.
   assign count_next_nopop = count_q + CNT_W'(fifo_push);
   assign in_ready_next    = ((CNT_W+1)'(count_next_nopop) + (CNT_W+1)'(pad_beat))
                             <= (CNT_W+1)'(IN_FIFO_DEPTH - 1);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge rstb) begin
      if (!rstb) begin
         in_ready_q  <= 1'b0;
         cap_valid_q <= 1'b0;
         cap_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         in_ovf      <= 1'b0;
      end else begin
         in_ready_q  <= in_ready_next;
         cap_valid_q <= pad_beat;
         if (pad_beat)   cap_q    <= {io_in[29], pad_data};
         if (fifo_push)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (fifo_pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (wr_blocked) in_ovf   <= 1'b1;
         case ({fifo_push, fifo_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign skid_push = s_valid & s_ready;
   assign out_load  = ~out_valid_q | io_in[18];
   assign skid_pop  = out_load & (skid_cnt_q != 2'd0);

   always_comb begin
      skid_cnt_next = skid_cnt_q + 2'(skid_push) - 2'(skid_pop);
   end

   always_ff @(posedge clock or negedge rstb) begin
      if (!rstb) begin
         skid_wr_q   <= 1'b0;
         skid_rd_q   <= 1'b0;
         skid_cnt_q  <= 2'd0;
         s_ready     <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else begin
         skid_cnt_q <= skid_cnt_next;
         s_ready    <= (skid_cnt_next != 2'd2);
         if (skid_push) skid_wr_q <= ~skid_wr_q;
         if (skid_pop)  skid_rd_q <= ~skid_rd_q;
         if (out_load) begin
            out_valid_q <= (skid_cnt_q != 2'd0);
            if (skid_pop) {out_last_q, out_data_q} <= skid_mem[skid_rd_q];
         end
      end
   end

   // NOTE: payload storage has no reset; validity lives entirely in the reset counters and pointers.
   always_ff @(posedge clock) begin
      if (fifo_push) fifo_mem[wr_ptr_q] <= cap_q;
      if (skid_push) skid_mem[skid_wr_q] <= {s_last, s_data};
   end

   assign io_out = {10'b0, in_ready_q, 9'b0, out_valid_q, out_last_q, out_data_q};
   assign io_oeb = {10'h3FF, 1'b0, 9'h1FF, 18'h0};

   logic unused_pins;
   assign unused_pins = ^{io_in[27:19], io_in[17:0]};

`ifdef MPRJ_STREAM_PAD_BRIDGE_CNT_EN
   logic out_beat;
   assign out_beat = out_valid_q & io_in[18];

   always_ff @(posedge clock or negedge rstb) begin
      if (!rstb) begin
         in_beats   <= '0;
         in_frames  <= '0;
         out_beats  <= '0;
         out_frames <= '0;
      end else begin
         in_beats   <= in_beats   + 16'(pad_beat);
         in_frames  <= in_frames  + 16'(pad_beat & io_in[29]);
         out_beats  <= out_beats  + 16'(out_beat);
         out_frames <= out_frames + 16'(out_beat & out_last_q);
      end
   end
`endif

endmodule

// File: tb/tb_mprj_stream_pad_bridge.sv
// Self-checking bench for mprj_stream_pad_bridge: vector table plus scoreboarded streams in both directions.
module tb_mprj_stream_pad_bridge;

   logic        clock = 1'b0;
   logic        rstb;
   logic [37:0] io_in, io_out, io_oeb;
   logic [7:0]  m_data;
   logic        m_valid, m_last, m_ready;
   logic [15:0] s_data;
   logic        s_valid, s_last, s_ready, in_ovf;
`ifdef MPRJ_STREAM_PAD_BRIDGE_CNT_EN
   logic [15:0] in_beats, out_beats, in_frames, out_frames;
`endif

   always #5 clock = ~clock;

   mprj_stream_pad_bridge dut (
      .clock   (clock),
      .rstb    (rstb),
      .io_in   (io_in),
      .io_out  (io_out),
      .io_oeb  (io_oeb),
      .m_data  (m_data),
      .m_valid (m_valid),
      .m_last  (m_last),
      .m_ready (m_ready),
      .s_data  (s_data),
      .s_valid (s_valid),
      .s_last  (s_last),
      .s_ready (s_ready),
      .in_ovf  (in_ovf)
`ifdef MPRJ_STREAM_PAD_BRIDGE_CNT_EN
      ,
      .in_beats   (in_beats),
      .out_beats  (out_beats),
      .in_frames  (in_frames),
      .out_frames (out_frames)
`endif
   );

   localparam logic [37:0] OEB_EXP = 38'h3F_F7FC_0000;

   typedef struct {
      logic [7:0]  pins;
      logic        last;
      logic [7:0]  exp_data;
      logic [15:0] word;
      logic [17:0] exp_pads;
   } vec_t;

   int checks = 0;
   int failures = 0;

   logic [8:0]  in_q [$];
   logic [16:0] eg_q [$];
   int in_total, in_sent, eg_total, eg_sent, eg_done_cnt;
   bit or_toggle;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int k = 0; k < 8; k++) r[k] = b[7-k];
      return r;
   endfunction

   function automatic logic [7:0] in_byte(input int i);
      return 8'(i * 37 + 11);
   endfunction

   task automatic drive_in();
      if (in_sent < in_total) begin
         io_in[28]    = 1'b1;
         io_in[29]    = (in_sent == in_total - 1);
         io_in[37:30] = rev8(in_byte(in_sent));
      end else begin
         io_in[28]    = 1'b0;
         io_in[29]    = 1'b0;
         io_in[37:30] = 8'h00;
      end
   endtask

   task automatic drive_eg();
      s_valid = (eg_sent < eg_total);
      s_data  = 16'(eg_sent);
      s_last  = (eg_sent == eg_total - 1);
   endtask

   // One clock of both scoreboards: decide handshakes at the negedge, advance sources after the edge.
   task automatic step();
      logic in_acc, eg_acc;
      logic [8:0]  ie;
      logic [16:0] ee;
      @(negedge clock);
      check("s_ready_vs_occupancy", s_ready, eg_q.size() < 3);
      if (in_q.size() == 0) check("ingress_spurious_valid", m_valid, 1'b0);
      else if (m_valid && m_ready) begin
         ie = in_q.pop_front();
         check("m_data", m_data, ie[7:0]);
         check("m_last", m_last, ie[8]);
      end
      in_acc = io_in[28] && io_out[27];
      if (in_acc) in_q.push_back({io_in[29], in_byte(in_sent)});
      if (eg_q.size() == 0) check("egress_spurious_valid", io_out[17], 1'b0);
      else if (io_out[17] && io_in[18]) begin
         ee = eg_q.pop_front();
         check("out_data", io_out[15:0], ee[15:0]);
         check("out_last", io_out[16], ee[16]);
         eg_done_cnt++;
      end else if (io_out[17]) check("out_hold", io_out[16:0], eg_q[0]);
      eg_acc = s_valid && s_ready;
      if (eg_acc) eg_q.push_back({s_last, s_data});
      @(posedge clock);
      #1;
      if (in_acc) in_sent++;
      if (eg_acc) eg_sent++;
      drive_in();
      drive_eg();
      if (or_toggle) io_in[18] = ~io_in[18];
   endtask

   task automatic run_until_done(input string name, input int budget, output int n);
      n = 0;
      while (!(in_sent == in_total && eg_sent == eg_total && in_q.size() == 0 && eg_q.size() == 0)
             && n < budget) begin
         step();
         n++;
      end
      check({name, "_complete"}, (in_total - in_sent) + (eg_total - eg_sent) + in_q.size() + eg_q.size(), 0);
   endtask

   task automatic do_reset();
      rstb = 1'b0;
      io_in = '0;
      m_ready = 1'b0;
      s_valid = 1'b0;
      s_data = '0;
      s_last = 1'b0;
      in_total = 0; in_sent = 0; eg_total = 0; eg_sent = 0; eg_done_cnt = 0;
      or_toggle = 1'b0;
      in_q.delete();
      eg_q.delete();
      repeat (2) @(posedge clock);
      @(negedge clock);
      rstb = 1'b1;
      repeat (2) @(posedge clock);
      #1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [8];
      int n;

      vecs[0] = '{8'h80, 1'b0, 8'h01, 16'h0001, 18'h20001};
      vecs[1] = '{8'h01, 1'b1, 8'h80, 16'h8000, 18'h38000};
      vecs[2] = '{8'hF0, 1'b0, 8'h0F, 16'hFFFF, 18'h2FFFF};
      vecs[3] = '{8'hA5, 1'b1, 8'hA5, 16'hA5A5, 18'h3A5A5};
      vecs[4] = '{8'h12, 1'b0, 8'h48, 16'h1234, 18'h21234};
      vecs[5] = '{8'hC1, 1'b1, 8'h83, 16'hBEEF, 18'h3BEEF};
      vecs[6] = '{8'h3C, 1'b0, 8'h3C, 16'h0000, 18'h20000};
      vecs[7] = '{8'hFF, 1'b1, 8'hFF, 16'h7FFE, 18'h37FFE};

      // Reset values, then in_ready one edge after release
      rstb = 1'b0; io_in = '0; m_ready = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_io_out", io_out, 38'h0);
      check("rst_io_oeb", io_oeb, OEB_EXP);
      check("rst_s_ready", s_ready, 1'b0);
      check("rst_m_valid", m_valid, 1'b0);
      check("rst_in_ovf", in_ovf, 1'b0);
      rstb = 1'b1;
      @(negedge clock);
      check("rel_in_ready", io_out[27], 1'b1);
      check("rel_s_ready", s_ready, 1'b1);
      check("rel_io_oeb", io_oeb, OEB_EXP);

      // Single-beat vectors in both directions with exact latency
      do_reset();
      io_in[18] = 1'b1;
      for (int v = 0; v < 8; v++) begin
         @(posedge clock);
         #1;
         io_in[28] = 1'b1; io_in[29] = vecs[v].last; io_in[37:30] = vecs[v].pins;
         s_valid = 1'b1; s_data = vecs[v].word; s_last = vecs[v].last;
         @(negedge clock);
         check("vec_in_ready", io_out[27], 1'b1);
         check("vec_s_ready", s_ready, 1'b1);
         @(posedge clock);
         #1;
         io_in[28] = 1'b0; s_valid = 1'b0;
         @(negedge clock);
         check("vec_m_valid_early", m_valid, 1'b0);
         check("vec_out_valid_early", io_out[17], 1'b0);
         @(negedge clock);
         check("vec_m_data", {m_valid, m_last, m_data}, {1'b1, vecs[v].last, vecs[v].exp_data});
         check("vec_out_pads", io_out[17:0], vecs[v].exp_pads);
         m_ready = 1'b1;
         @(posedge clock);
         #1;
         m_ready = 1'b0;
         @(negedge clock);
         check("vec_m_valid_popped", m_valid, 1'b0);
         check("vec_out_valid_done", io_out[17], 1'b0);
      end

      // Ingress stream of 2048 bytes at full rate
      do_reset();
      in_total = 2048;
      m_ready = 1'b1;
      drive_in();
      run_until_done("in_stream", 6000, n);
      check("in_stream_rate", n <= 2052, 1'b1);
      check("in_stream_ovf", in_ovf, 1'b0);
`ifdef MPRJ_STREAM_PAD_BRIDGE_CNT_EN
      check("in_stream_beats", in_beats, 16'd2048);
      check("in_stream_frames", in_frames, 16'd1);
`endif

      // Ingress backpressure: exactly IN_FIFO_DEPTH beats stored, then drain in order
      do_reset();
      in_total = 24;
      drive_in();
      repeat (16) step();
      check("bp_in_ready_low", io_out[27], 1'b0);
      check("bp_accepted", in_sent, 8);
      check("bp_m_head", {m_valid, m_data}, {1'b1, in_byte(0)});
      m_ready = 1'b1;
      run_until_done("bp_drain", 500, n);
      check("bp_ovf", in_ovf, 1'b0);

      // Egress stream of 512 words at full rate
      do_reset();
      io_in[18] = 1'b1;
      eg_total = 512;
      drive_eg();
      run_until_done("eg_stream", 3000, n);
      check("eg_stream_rate", n <= 516, 1'b1);
      check("eg_stream_count", eg_done_cnt, 512);
`ifdef MPRJ_STREAM_PAD_BRIDGE_CNT_EN
      check("eg_stream_beats", out_beats, 16'd512);
      check("eg_stream_frames", out_frames, 16'd1);
`endif

      // Egress stall: output register plus two skid entries fill, then s_ready drops
      do_reset();
      eg_total = 8;
      drive_eg();
      repeat (6) step();
      check("stall_accepted", eg_sent, 3);
      check("stall_s_ready", s_ready, 1'b0);
      check("stall_out_head", io_out[17:0], 18'h20000);
      or_toggle = 1'b1;
      run_until_done("stall_drain", 200, n);
      check("stall_count", eg_done_cnt, 8);

      // Egress stream with out_ready toggling every cycle
      do_reset();
      io_in[18] = 1'b1;
      or_toggle = 1'b1;
      eg_total = 512;
      drive_eg();
      run_until_done("eg_toggle", 4000, n);
      check("eg_toggle_count", eg_done_cnt, 512);

      // Reset in the middle of frames in both directions, then a clean frame
      do_reset();
      io_in[18] = 1'b1;
      m_ready = 1'b1;
      in_total = 300;
      eg_total = 300;
      drive_in();
      drive_eg();
      n = 0;
      while (eg_sent < 100 && n < 1000) begin
         step();
         n++;
      end
      check("mid_reached_beat100", eg_sent >= 100 && in_sent >= 100, 1'b1);
      #2;
      rstb = 1'b0;
      #1;
      check("mid_io_out", io_out, 38'h0);
      check("mid_io_oeb", io_oeb, OEB_EXP);
      check("mid_m_valid", m_valid, 1'b0);
      check("mid_s_ready", s_ready, 1'b0);
`ifdef MPRJ_STREAM_PAD_BRIDGE_CNT_EN
      check("mid_counters", {in_beats, in_frames, out_beats, out_frames}, 64'h0);
`endif
      do_reset();
      io_in[18] = 1'b1;
      m_ready = 1'b1;
      in_total = 20;
      eg_total = 20;
      drive_in();
      drive_eg();
      run_until_done("post_reset_frame", 500, n);
      check("post_reset_eg_count", eg_done_cnt, 20);
      check("post_reset_ovf", in_ovf, 1'b0);
`ifdef MPRJ_STREAM_PAD_BRIDGE_CNT_EN
      check("post_reset_counters", {in_beats, in_frames, out_beats, out_frames},
            {16'd20, 16'd1, 16'd20, 16'd1});
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
